ext_pipe: RTL

EXT_PIPE -- requirements
Module: ext_pipe

---
 rtl/ext_pkg.sv | 23 ++
 rtl/ext_core.sv | 66 ++++++
 rtl/ext_pipe.sv | 95 +++++++++
 3 files changed

// File: rtl/ext_pkg.sv
// ============================================================================
// Module      : ext_pkg
// Description : Op-code constants and op-field width shared by ext_core/ext_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ext_pkg;

   localparam int OPW = 3;

   localparam logic [OPW-1:0] OP_SEXT = 3'd0;
   localparam logic [OPW-1:0] OP_ZEXT = 3'd1;
   localparam logic [OPW-1:0] OP_HIGH = 3'd2;
   localparam logic [OPW-1:0] OP_LB   = 3'd3;
   localparam logic [OPW-1:0] OP_LBU  = 3'd4;
   localparam logic [OPW-1:0] OP_LH   = 3'd5;
   localparam logic [OPW-1:0] OP_LHU  = 3'd6;
   localparam logic [OPW-1:0] OP_EXT7 = 3'd7;

endpackage

`default_nettype wire

// File: rtl/ext_core.sv
// ============================================================================
// Module      : ext_core
// Description : Combinational sign/zero-extend and load-extend datapath.
//               Op 7 is a byte reverse when EXT_BSWAP_EN is defined,
//               otherwise a pass-through.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ext_core
   import ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic [OUT_W-1:0]            data_i,
   input  logic [OPW-1:0]              op_i,
   input  logic [$clog2(OUT_W/8)-1:0]  off_i,
   output logic [OUT_W-1:0]            result_o,
   output logic                        err_o
);

   localparam int NB = OUT_W / 8;

   logic [IN_W-1:0]  w_imm;
   logic [15:0]      w_half;
   logic [7:0]       w_byte;
   logic [OUT_W-1:0] w_op7;

   assign w_imm  = data_i[IN_W-1:0];
   // Little-endian byte lanes: byte in_off ends up in bits [7:0].
   assign w_half = 16'(data_i >> {off_i, 3'b000});
   assign w_byte = w_half[7:0];

`ifdef EXT_BSWAP_EN
   for (genvar i = 0; i < NB; i++) begin : g_bswap
      assign w_op7[8*i +: 8] = data_i[8*(NB-1-i) +: 8];
   end
`else
   assign w_op7 = data_i;
`endif

   always_comb begin
      result_o = '0;
      err_o    = 1'b0;
      case (op_i)
         OP_SEXT: result_o = {{(OUT_W-IN_W){w_imm[IN_W-1]}}, w_imm};
         OP_ZEXT: result_o = {{(OUT_W-IN_W){1'b0}}, w_imm};
         OP_HIGH: result_o = {w_imm, {(OUT_W-IN_W){1'b0}}};
         OP_LB:   result_o = {{(OUT_W-8){w_byte[7]}}, w_byte};
         OP_LBU:  result_o = {{(OUT_W-8){1'b0}}, w_byte};
         OP_LH: begin
            if (off_i[0]) err_o = 1'b1;
            else          result_o = {{(OUT_W-16){w_half[15]}}, w_half};
         end
         OP_LHU: begin
            if (off_i[0]) err_o = 1'b1;
            else          result_o = {{(OUT_W-16){1'b0}}, w_half};
         end
         default: result_o = w_op7;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/ext_pipe.sv
// ============================================================================
// Module      : ext_pipe
// Description : Extend unit behind a 2-entry result FIFO with valid/ready
//               handshakes. Optional feature macro: EXT_BSWAP_EN (op 7 BSWAP).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ext_pipe
   import ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [OUT_W-1:0]            in_data,
   input  logic [OPW-1:0]              in_op,
   input  logic [$clog2(OUT_W/8)-1:0]  in_off,
   input  logic                        flush,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [OUT_W-1:0]            out_data,
   output logic                        out_err
);

   logic [OUT_W-1:0]     w_result;
   logic                 w_err;
   logic                 w_push;
   logic                 w_pop;

   logic [1:0][OUT_W:0]  mem_q, mem_d;
   logic                 wr_ptr_q, wr_ptr_d;
   logic                 rd_ptr_q, rd_ptr_d;
   logic [1:0]           count_q, count_d;

   ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .data_i   (in_data),
      .op_i     (in_op),
      .off_i    (in_off),
      .result_o (w_result),
      .err_o    (w_err)
   );

   // Handshake outputs come only from registered state.
   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign {out_err, out_data} = out_valid ? mem_q[rd_ptr_q] : '0;

   assign w_push = in_valid && in_ready && !flush;
   assign w_pop  = out_valid && out_ready && !flush;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (w_push) begin
            mem_d[wr_ptr_q] = {w_err, w_result};
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (w_pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

`default_nettype wire
